// File: rtl/timer_pkg.sv
// Shared types for the multi-channel timer: channel mode and channel state encodings.
package timer_pkg;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONE_SHOT = 1'b1
  } timer_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period register, up-counter and IDLE/RUN/HOLD state machine.
// All outputs are registered; the compare always uses the period held before a load.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned            COUNT_WIDTH    = 32,
  parameter logic [COUNT_WIDTH-1:0] DEFAULT_PERIOD = COUNT_WIDTH'(100)
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  timer_mode_t            mode_i,
  input  logic                   load_i,
  input  logic [COUNT_WIDTH-1:0] period_i,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] count_o
);

  timer_state_t           state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] period_q;
  logic [COUNT_WIDTH-1:0] last_count;
  logic                   done_q, done_d;
  logic                   expire;

  // A zero period behaves like a period of one: expire on every enabled edge.
  assign last_count = (period_q == '0) ? '0 : period_q - COUNT_WIDTH'(1);
  // IDLE holds count at zero, so the same compare gives IDLE its "act as RUN" behaviour.
  assign expire     = (state_q != HOLD) && (count_q >= last_count);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
      period_q <= DEFAULT_PERIOD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      if (load_i) begin
        period_q <= period_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, RUN: state_d = (expire && mode_i == ONE_SHOT) ? HOLD : RUN;
        HOLD:      state_d = HOLD;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = '0;
    done_d  = 1'b0;
    if (enable_i && state_q != HOLD) begin
      if (expire) begin
        done_d = 1'b1;
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign done_o  = done_q;
  assign busy_o  = (state_q == RUN);
  assign count_o = count_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Array of independent timer channels sharing one clock, reset and period bus.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS       = 4,
  parameter int unsigned COUNT_WIDTH        = 32,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000,
  parameter int unsigned DEFAULT_PERIOD     = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY
) (
  input  logic                                clock_i,
  input  logic                                reset_n_i,
  input  logic [NUM_CHANNELS-1:0]             enable_i,
  input  logic [NUM_CHANNELS-1:0]             mode_i,
  input  logic [NUM_CHANNELS-1:0]             load_i,
  input  logic [COUNT_WIDTH-1:0]              period_i,
  output logic [NUM_CHANNELS-1:0]             done_o,
  output logic [NUM_CHANNELS-1:0]             busy_o,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] count_o
);

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_channel
    timer_channel #(
      .COUNT_WIDTH   (COUNT_WIDTH),
      .DEFAULT_PERIOD(COUNT_WIDTH'(DEFAULT_PERIOD))
    ) u_channel (
      .clock_i  (clock_i),
      .reset_n_i(reset_n_i),
      .enable_i (enable_i[k]),
      .mode_i   (timer_mode_t'(mode_i[k])),
      .load_i   (load_i[k]),
      .period_i (period_i),
      .done_o   (done_o[k]),
      .busy_o   (busy_o[k]),
      .count_o  (count_o[k*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

endmodule

// File: doc/multi_channel_timer.md
# multi_channel_timer

Parametrised, multi-channel successor to the single-channel sampling timer. Provides `NUM_CHANNELS` independent down-the-line tick sources, each with a runtime-loadable period and a periodic or one-shot mode. Each channel emits single-cycle `done` pulses for the sampling/ADC and audio blocks that sit downstream. All channels share one clock and one synchronous reset.

## Interface

- `NUM_CHANNELS`, 4, number of independent timer channels (≥1)
- `COUNT_WIDTH`, 32, width of period and count registers (≥2)
- `SYSTEM_FREQUENCY`, 100000000, clock frequency in Hz
- `SAMPLING_FREQUENCY`, 1000000, default tick rate in Hz
- `DEFAULT_PERIOD`, `SYSTEM_FREQUENCY/SAMPLING_FREQUENCY` (=100), period loaded at reset

Ports:

- `clock_i` in 1: single system clock, all logic on rising edge
- `reset_n_i` in 1: reset, synchronous, active-low
- `enable_i` in `NUM_CHANNELS`: per-channel run level
- `mode_i` in `NUM_CHANNELS`: per-channel mode, 0 = periodic, 1 = one-shot; sampled every cycle
- `load_i` in `NUM_CHANNELS`: per-channel one-cycle strobe to latch `period_i`
- `period_i` in `COUNT_WIDTH`: shared period bus
- `done_o` out `NUM_CHANNELS`: one-cycle registered expiry pulse per channel
- `busy_o` out `NUM_CHANNELS`: channel in RUN state
- `count_o` out `NUM_CHANNELS*COUNT_WIDTH`: flattened current counts; channel k occupies bits `[k*COUNT_WIDTH +: COUNT_WIDTH]`

## Operation

- Per-channel state machine with three states:
  - IDLE: count = 0, `busy` = 0. Any edge with `enable`=1 behaves as RUN on that same edge (count increments to 1), and the state becomes RUN.
  - RUN: each edge with `enable`=1 evaluates `count >= P-1`.
    - If true: count ← 0 and `done` ← 1.
    - If false: count ← count+1 and `done` ← 0.
    - In one-shot mode, expiry moves the channel to HOLD; otherwise it stays in RUN.
  - HOLD (one-shot only): count = 0, `done` = 0, `busy` = 0. No further pulses until `enable` is seen low. There is no other exit from HOLD.
- `enable`=0 in any state: next edge gives count ← 0, `done` ← 0, state ← IDLE.
- Effective period P = period register, except that 0 is treated as 1 (`done` high every enabled cycle).
- Load:
  - Any edge with `load_i[k]`=1 latches `period_i` into channel k's period register.
  - Load is independent of `enable` and state, and does not reset count.
  - The comparison on that same edge uses the old period.
  - The `>=` compare guarantees that shrinking the period below the current count expires on the next enabled edge. There is no wrap-around through 2^`COUNT_WIDTH`.
- Counter arithmetic is unsigned, `COUNT_WIDTH` bits. Count never exceeds P-1 except transiently after a shrinking load.
- Channels are fully independent. Simultaneous expiry on several channels gives simultaneous `done` bits.

## Timing

- Reset (`reset_n_i`=0 sampled on an edge):
  - all `done_o` = 0, `busy_o` = 0, `count_o` = 0
  - state = IDLE
  - every period register = `DEFAULT_PERIOD`
- Reset overrides `load_i` and `enable_i` on the same edge. Reset mid-count aborts with no `done`.
- With `enable` high from edge 1 onward: `done_o` is high in the cycle after edge P, i.e. it is registered and asserted P cycles after `enable` is first sampled.
  - Periodic mode: pulses repeat every P cycles, exactly one cycle wide.
  - Periodic mode with P=1: `done` is held continuously high.
- `busy_o` and `count_o` are registered, with the same cycle alignment as `done_o`.
- `mode_i` change mid-run takes effect at the next expiry decision.
- No combinational path from any input to any output.

## Structure

- `timer_pkg`: `timer_mode_t` enum (PERIODIC, ONE_SHOT) and `timer_state_t` enum (IDLE, RUN, HOLD).
- Sub-module `timer_channel`: one state machine, period register and counter, parameterised by `COUNT_WIDTH` and `DEFAULT_PERIOD`.
- Top level is a generate loop over `NUM_CHANNELS` plus `count_o` flattening.

## Test plan

- Reset, then `enable_i`=4'b0001 with default period -> `done_o[0]` pulses in cycles 100, 200, 300; other channels `done` = 0, `count` = 0.
- Load `period_i`=5 on ch1, `mode_i[1]`=1, enable -> one `done_o[1]` pulse 5 cycles later, then `busy_o[1]`=0 and no pulse for 50 cycles; drop and re-raise enable -> pulse again after 5 cycles.
- Ch2 period 1000, run to count 600, load 10 -> `done_o[2]` on the next enabled edge, then every 10 cycles.
- `period_i`=0 on ch3 -> `done_o[3]` high every enabled cycle; `period_i`=1 gives the same result.
- Ch0 enabled at count 40, `reset_n_i` low one cycle -> no `done`, count 0, period back to 100; next pulse 100 cycles after reset release.
- Ch0 period 3 and ch1 period 6, enabled on the same edge -> both `done` bits high together every 6 cycles, ch0 alone otherwise.
